// File: rtl/status_value_vector_pkg.sv
// Shared helpers for status_value_vector_fifo: log2 sizing and
// pointer stepping with wrap at an arbitrary (non power-of-two) depth.
package status_value_vector_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // Wraps explicitly so depths that are not a power of two work.
  function automatic int unsigned ptr_step(input int unsigned ptr,
                                           input int unsigned depth,
                                           input bit          dec);
    if (dec) return (ptr == 0) ? depth - 1 : ptr - 1;
    else     return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/status_value_vector_fifo_svv_storage.sv
// DEPTH x WIDTH status register array: one push write port, one set write port.
// STATUS_VALUE_VECTOR_MEM_RESET_EN adds an asynchronous clear of every entry.
module svv_storage #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int PW    = 3
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             push_we,
  input  logic [PW-1:0]    push_addr,
  input  logic [WIDTH-1:0] push_data,
  input  logic             set_we,
  input  logic [PW-1:0]    set_addr,
  input  logic [WIDTH-1:0] set_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] status_vector_q [DEPTH];

  // Push and set never hit the same slot in one cycle, so no priority is needed.
`ifdef STATUS_VALUE_VECTOR_MEM_RESET_EN
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int i = 0; i < DEPTH; i++) status_vector_q[i] <= '0;
    end else begin
      if (push_we) status_vector_q[push_addr] <= push_data;
      if (set_we)  status_vector_q[set_addr]  <= set_data;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (push_we) status_vector_q[push_addr] <= push_data;
    if (set_we)  status_vector_q[set_addr]  <= set_data;
  end
`endif

  assign rd_data = status_vector_q[rd_addr];

endmodule

// File: rtl/status_value_vector_fifo.sv
// Status FIFO with in-place update of the newest entry (set path, SET_EN).
// STATUS_VALUE_VECTOR_MEM_RESET_EN selects whether storage is cleared on reset.
module status_value_vector_fifo
  import status_value_vector_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter bit SET_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             push_i,
  input  logic             pull_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] value_o,
  output logic             valid_o,
  output logic             full_o,
  input  logic             set_i,
  input  logic [WIDTH-1:0] set_value_i
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW-1:0]    rd_ptr_inc, wr_ptr_inc, wr_ptr_dec;
  logic [CW-1:0]    count;
  logic             push_ok, pull_ok, set_ok;
  logic [WIDTH-1:0] head;

  assign valid_o = (count != '0);
  assign full_o  = (count == CW'(DEPTH));

  assign pull_ok = pull_i && valid_o;
  assign push_ok = push_i && (!full_o || pull_ok);
  assign set_ok  = SET_EN && set_i && valid_o;

  assign rd_ptr_inc = PW'(ptr_step(32'(rd_ptr), DEPTH, 1'b0));
  assign wr_ptr_inc = PW'(ptr_step(32'(wr_ptr), DEPTH, 1'b0));
  assign wr_ptr_dec = PW'(ptr_step(32'(wr_ptr), DEPTH, 1'b1));

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pull_ok) rd_ptr <= rd_ptr_inc;
      if (push_ok) wr_ptr <= wr_ptr_inc;
      case ({push_ok, pull_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  svv_storage #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_storage (
    .clk_i     (clk_i),
    .rsn_i     (rsn_i),
    .push_we   (push_ok),
    .push_addr (wr_ptr),
    .push_data (value_i),
    .set_we    (set_ok),
    .set_addr  (wr_ptr_dec),
    .set_data  (set_value_i),
    .rd_addr   (rd_ptr),
    .rd_data   (head)
  );

  // Masking the head when empty hides whether storage was ever reset.
  assign value_o = valid_o ? head : '0;

endmodule

// File: tb/tb_status_value_vector_fifo.sv
// Scoreboard bench for status_value_vector_fifo against a queue-based FIFO model.
module tb_status_value_vector_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic             valid;
    logic             full;
    logic [WIDTH-1:0] value;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rsn_i = 1'b0;
  logic             push_i = 1'b0, pull_i = 1'b0, set_i = 1'b0;
  logic [WIDTH-1:0] value_i = '0, set_value_i = '0;
  logic [WIDTH-1:0] value_o;
  logic             valid_o, full_o;

  int tests = 0;
  int fails = 0;
  bit done  = 1'b0;

  logic [WIDTH-1:0] model [$];
  exp_t             exp_q [$];

  status_value_vector_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SET_EN(1'b1)) dut (
    .clk_i       (clk_i),
    .rsn_i       (rsn_i),
    .push_i      (push_i),
    .pull_i      (pull_i),
    .value_i     (value_i),
    .value_o     (value_o),
    .valid_o     (valid_o),
    .full_o      (full_o),
    .set_i       (set_i),
    .set_value_i (set_value_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.valid = (model.size() > 0);
    e.full  = (model.size() == DEPTH);
    e.value = e.valid ? model[0] : '0;
    return e;
  endfunction

  // One cycle of stimulus; the model applies the FIFO rules on pre-edge occupancy.
  task automatic step(input bit p, input bit l, input bit s,
                      input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] sv);
    bit pl, ps;
    @(negedge clk_i);
    rsn_i = 1'b1;
    push_i = p; pull_i = l; set_i = s; value_i = v; set_value_i = sv;
    if (s && model.size() > 0) model[model.size()-1] = sv;
    pl = l && (model.size() > 0);
    ps = p && ((model.size() < DEPTH) || pl);
    if (pl) void'(model.pop_front());
    if (ps) model.push_back(v);
    exp_q.push_back(model_view());
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      rsn_i = 1'b0;
      push_i = 1'b0; pull_i = 1'b0; set_i = 1'b0;
      model.delete();
      exp_q.push_back(model_view());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
  endtask

  // Monitor: compares whatever the DUT presents after each edge with the oldest expectation.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid_o", 32'(valid_o), 32'(e.valid));
        check("full_o",  32'(full_o),  32'(e.full));
        check("value_o", 32'(value_o), 32'(e.value));
      end
    end
  end

  initial begin
    // Reset then idle
    rst_cycles(4);
    idle(2);

    // Three pushes then three pulls
    step(1, 0, 0, 8'h11, '0);
    step(1, 0, 0, 8'h22, '0);
    step(1, 0, 0, 8'h33, '0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0, '0);
    idle(1);

    // Fill, dropped ninth push, drain across the wrap
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 8'(i), '0);
    step(1, 0, 0, 8'hFF, '0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, '0, '0);
    idle(1);

    // Full with simultaneous push and pull
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 8'(i), '0);
    step(1, 1, 0, 8'h99, '0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, '0, '0);

    // Set newest entry; set with push; set on empty
    step(1, 0, 0, 8'hAA, '0);
    step(1, 0, 0, 8'hBB, '0);
    step(0, 0, 1, '0, 8'h5C);
    step(1, 0, 1, 8'hCD, 8'h77);
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0, '0);
    step(0, 0, 1, '0, 8'hE1);
    idle(1);

    // Set together with a pull of the sole entry; push+pull on empty
    step(1, 0, 0, 8'h42, '0);
    step(0, 1, 1, '0, 8'h24);
    step(1, 1, 0, 8'h63, '0);
    step(0, 1, 0, '0, '0);

    // Reset mid-operation, then first push after release
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h50 + i), '0);
    rst_cycles(2);
    step(1, 0, 0, 8'h3E, '0);
    step(0, 1, 0, '0, '0);

    // Randomized mix with periodic reset; push bias alternates to reach full and empty
    for (int i = 0; i < 3200; i++) begin
      int pp;
      if (i % 400 == 0) rst_cycles(2);
      pp = ((i / 400) % 2 == 0) ? 70 : 35;
      step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 20, WIDTH'($urandom), WIDTH'($urandom));
    end
    idle(2);

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk_i);
        budget--;
      end
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
